melody_player: RTL and testbench

Programmable multi-song note sequencer and square-wave tone generator for the piezo. It replaces fixed per-state tone selection with a writable note table of NUM_SONGS songs × MAX_NOTES entries, each holding a divider and a duration. The FSM controller starts, preempts or stops playback with single-cycle requests and gets back busy/done status. It sits between the game FSM and the piezo pin.

---
 rtl/melody_player.sv | 225 ++++++++++++++++++++++
 tb/tb_melody_player.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_player.sv
// melody_player: programmable multi-song note sequencer and square-wave tone
// generator for the piezo.
//   clk, rst_n         : system clock, asynchronous active-low reset
//   wr_en/addr/data    : note table write port, addr = {song, index}, data = {div, dur}
//   play/song_sel/loop : start (or preempt) playback of a song, optionally repeating
//   stop               : abort playback
//   piezo_out          : registered square wave, half-period = div cycles
//   busy, done         : playback active / one-cycle natural-end pulse
//   note_idx           : index of the entry currently loaded or playing
module melody_player #(
    parameter int unsigned NUM_SONGS = 4,
    parameter int unsigned MAX_NOTES = 8,
    parameter int unsigned DIV_W     = 20,
    parameter int unsigned DUR_W     = 24,
    parameter int unsigned GAP_CYC   = 0,
    localparam int unsigned SONG_W   = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int unsigned IDX_W    = $clog2(MAX_NOTES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [SONG_W+IDX_W-1:0] wr_addr,
    input  logic [DIV_W+DUR_W-1:0]  wr_data,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song_sel,
    input  logic                    loop,
    input  logic                    stop,
    output logic                    piezo_out,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        note_idx
);

    localparam int unsigned ADDR_W  = SONG_W + IDX_W;
    localparam int unsigned WORD_W  = DIV_W + DUR_W;
    localparam int unsigned DEPTH   = NUM_SONGS * MAX_NOTES;
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
    localparam int unsigned SONG_W1 = SONG_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic                loop_q, loop_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [DIV_W-1:0]    tone_cnt_q, tone_cnt_d;
    logic                tone_q, tone_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [WORD_W-1:0]   table_mem [DEPTH];
    logic [WORD_W-1:0]   rd_data_q;
    logic [DIV_W-1:0]    rd_div_c;
    logic [DUR_W-1:0]    rd_dur_c;
    logic [ADDR_W-1:0]   rd_addr_c;
    logic                rd_en_c;
    logic                wr_ok_c;
    logic                play_ok_c;
    logic                adv_c;
    logic                term_c;

    // Guard against song numbers beyond the table when NUM_SONGS is not a power of two
    assign wr_ok_c   = {1'b0, wr_addr[ADDR_W-1 -: SONG_W]} < SONG_W1'(NUM_SONGS);
    assign play_ok_c = play && ({1'b0, song_sel} < SONG_W1'(NUM_SONGS));

    // The read is issued on the edge that enters LOAD so the entry is visible during LOAD
    assign rd_en_c   = (state_d == LOAD);
    assign rd_addr_c = {song_d, idx_d};
    assign rd_dur_c  = rd_data_q[DUR_W-1:0];
    assign rd_div_c  = rd_data_q[WORD_W-1:DUR_W];

    // Note table: synchronous RAM, not reset, read-during-write returns old data
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok_c) begin
            table_mem[wr_addr] <= wr_data;
        end
        if (rd_en_c) begin
            rd_data_q <= table_mem[rd_addr_c];
        end
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            song_q     <= '0;
            loop_q     <= 1'b0;
            idx_q      <= '0;
            div_q      <= '0;
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            gap_cnt_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            loop_q     <= loop_d;
            idx_q      <= idx_d;
            div_q      <= div_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            gap_cnt_q  <= gap_cnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        loop_d     = loop_q;
        idx_d      = idx_q;
        div_d      = div_q;
        dur_cnt_d  = dur_cnt_q;
        tone_cnt_d = tone_cnt_q;
        tone_d     = 1'b0;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 1'b0;
        adv_c      = 1'b0;
        term_c     = 1'b0;

        case (state_q)
            IDLE: begin
            end
            LOAD: begin
                if (rd_dur_c != '0) begin
                    state_d    = PLAY;
                    div_d      = rd_div_c;
                    dur_cnt_d  = rd_dur_c;
                    tone_cnt_d = '0;
                end else begin
                    term_c = 1'b1;
                end
            end
            PLAY: begin
                dur_cnt_d = dur_cnt_q - DUR_W'(1);
                if (div_q != '0) begin
                    if (tone_cnt_q == div_q - DIV_W'(1)) begin
                        tone_cnt_d = '0;
                        tone_d     = ~tone_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + DIV_W'(1);
                        tone_d     = tone_q;
                    end
                end
                if (dur_cnt_q == DUR_W'(1)) begin
                    if (GAP_CYC > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_W'(GAP_CYC);
                    end else begin
                        adv_c = 1'b1;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q == GAP_W'(1)) begin
                    adv_c = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Running off the end of the table behaves like hitting a terminator
        if (adv_c) begin
            if (idx_q == IDX_W'(MAX_NOTES - 1)) begin
                term_c = 1'b1;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = LOAD;
            end
        end

        // An empty song never loops, so loop only restarts from a non-zero index
        if (term_c) begin
            if (loop_q && (idx_q != '0)) begin
                idx_d   = '0;
                state_d = LOAD;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // Start or preempt; an aborted song never reports done
        if (play_ok_c) begin
            state_d = LOAD;
            song_d  = song_sel;
            loop_d  = loop;
            idx_d   = '0;
            done_d  = 1'b0;
        end

        if (stop) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        if (state_d != PLAY) begin
            tone_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign piezo_out = tone_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign note_idx  = idx_q;

endmodule

// File: tb/tb_melody_player.sv
// Self-checking bench for melody_player: directed scenarios plus randomized
// note tables, checked cycle by cycle against a waveform model built from the
// note table (LOAD cycle, dur cycles of square wave, gap, terminator rules).
module tb_melody_player;

    localparam int unsigned NS    = 3;
    localparam int unsigned MN    = 8;
    localparam int unsigned DIV_W = 20;
    localparam int unsigned DUR_W = 24;
    localparam int unsigned GAP   = 0;
    localparam int unsigned SW    = 2;
    localparam int unsigned IW    = 3;
    localparam int unsigned OBS_N = 200;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  wr_en;
    logic [SW+IW-1:0]      wr_addr;
    logic [DIV_W+DUR_W-1:0] wr_data;
    logic                  play;
    logic [SW-1:0]         song_sel;
    logic                  loop;
    logic                  stop;
    logic                  piezo_out;
    logic                  busy;
    logic                  done;
    logic [IW-1:0]         note_idx;

    melody_player #(
        .NUM_SONGS (NS),
        .MAX_NOTES (MN),
        .DIV_W     (DIV_W),
        .DUR_W     (DUR_W),
        .GAP_CYC   (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .play      (play),
        .song_sel  (song_sel),
        .loop      (loop),
        .stop      (stop),
        .piezo_out (piezo_out),
        .busy      (busy),
        .done      (done),
        .note_idx  (note_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int tbl_div [NS][MN];
    int tbl_dur [NS][MN];

    typedef struct {
        logic p;
        logic b;
        logic d;
        int   idx;
    } exp_t;
    exp_t tr[$];

    logic obs_p [OBS_N];
    logic obs_b [OBS_N];
    logic obs_d [OBS_N];
    int   obs_idx [OBS_N];

    task automatic push(input logic p, input logic b, input logic d, input int idx);
        exp_t e;
        e.p = p; e.b = b; e.d = d; e.idx = idx;
        tr.push_back(e);
    endtask

    // Expected waveform, one entry per cycle starting with the cycle after the play edge
    task automatic build_trace(input int song, input bit lp, input int maxlen);
        int idx;
        int dv;
        int du;
        bit fin;
        idx = 0;
        fin = 1'b0;
        tr.delete();
        while (!fin && tr.size() < maxlen) begin
            dv = tbl_div[song][idx];
            du = tbl_dur[song][idx];
            push(1'b0, 1'b1, 1'b0, idx);
            if (du == 0) begin
                if (lp && idx != 0) idx = 0;
                else fin = 1'b1;
            end else begin
                for (int k = 0; k < du; k++)
                    push((dv != 0) ? (((k / dv) % 2) == 1) : 1'b0, 1'b1, 1'b0, idx);
                for (int g = 0; g < int'(GAP); g++)
                    push(1'b0, 1'b1, 1'b0, idx);
                if (idx == int'(MN) - 1) begin
                    if (lp) idx = 0;
                    else fin = 1'b1;
                end else begin
                    idx++;
                end
            end
        end
        if (fin) begin
            push(1'b0, 1'b0, 1'b1, idx);
            push(1'b0, 1'b0, 1'b0, idx);
            push(1'b0, 1'b0, 1'b0, idx);
        end
    endtask

    task automatic compare_cycle(input string name, input int i);
        exp_t e;
        e = tr[i];
        if (i < int'(OBS_N)) begin
            obs_p[i] = piezo_out; obs_b[i] = busy; obs_d[i] = done; obs_idx[i] = int'(note_idx);
        end
        n_checks++;
        if (piezo_out !== e.p || busy !== e.b || done !== e.d ||
            (e.b && note_idx !== IW'(e.idx))) begin
            n_fail++;
            $display("FAIL %s cycle %0d: piezo/busy/done/idx got %b%b%b/%0d, expected %b%b%b/%0d",
                     name, i + 1, piezo_out, busy, done, note_idx, e.p, e.b, e.d, e.idx);
        end
    endtask

    // Called at a falling edge; issues play and checks n cycles (0 = whole trace)
    task automatic run_song(input string name, input int song, input bit lp, input int n);
        int cnt;
        build_trace(song, lp, 400);
        cnt = (n == 0 || n > tr.size()) ? tr.size() : n;
        play = 1'b1; song_sel = SW'(song); loop = lp;
        @(posedge clk);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            if (i == 0) begin play = 1'b0; loop = 1'b0; end
            compare_cycle(name, i);
        end
    endtask

    task automatic write_entry(input int song, input int idx, input int dv, input int du);
        wr_en = 1'b1;
        wr_addr = {SW'(song), IW'(idx)};
        wr_data = {DIV_W'(dv), DUR_W'(du)};
        @(negedge clk);
        wr_en = 1'b0;
        tbl_div[song][idx] = dv;
        tbl_dur[song][idx] = du;
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            n_checks++;
            if (piezo_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle+%0d: piezo/busy/done got %b%b%b, expected 000",
                         name, i, piezo_out, busy, done);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_stop(input string name);
        stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stop = 1'b0;
        check_idle(name, 3);
    endtask

    task automatic check_obs(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        play = 1'b0; song_sel = '0; loop = 1'b0; stop = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (piezo_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || note_idx !== '0) begin
            n_fail++;
            $display("FAIL reset: piezo/busy/done/idx got %b%b%b/%0d, expected 000/0",
                     piezo_out, busy, done, note_idx);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_release", 2);
    endtask

    task automatic setup_tables();
        for (int s = 0; s < int'(NS); s++)
            for (int i = 0; i < int'(MN); i++)
                write_entry(s, i, 0, 0);
        write_entry(0, 0, 4, 20);
        write_entry(0, 1, 0, 6);
        for (int i = 0; i < int'(MN); i++) write_entry(1, i, 2, 3);
        write_entry(2, 0, 3, 9);
        write_entry(2, 1, 1, 4);
    endtask

    task automatic test_song0();
        run_song("song0", 0, 1'b0, 0);
        check_obs("song0_first_rise_t6", obs_p[5], 1'b1);
        check_obs("song0_low_t10", obs_p[9], 1'b0);
        check_obs("song0_high_t14", obs_p[13], 1'b1);
        check_obs("song0_rest_silent", obs_p[24], 1'b0);
        check_obs("song0_done_t30", obs_d[29], 1'b1);
        check_obs("song0_busy_low_t30", obs_b[29], 1'b0);
        check_obs("song0_busy_high_t29", obs_b[28], 1'b1);
    endtask

    task automatic test_loop();
        run_song("loop0", 0, 1'b1, 70);
        check_obs("loop0_wrap_busy", obs_b[29], 1'b1);
        check_obs("loop0_no_done", obs_d[29], 1'b0);
        check_obs("loop0_second_rise", obs_p[34], 1'b1);
        do_stop("loop0_stop");
    endtask

    task automatic test_full_song();
        run_song("song1_full", 1, 1'b0, 0);
        check_obs("song1_idx7", (obs_idx[28] == 7), 1'b1);
        check_obs("song1_done_t33", obs_d[32], 1'b1);
        check_obs("song1_busy_t32", obs_b[31], 1'b1);
    endtask

    task automatic test_preempt();
        run_song("preempt_song1", 1, 1'b0, 10);
        run_song("preempt_song2", 2, 1'b0, 0);
        check_obs("preempt_idx0", (obs_idx[0] == 0), 1'b1);
        check_obs("preempt_song2_rise", obs_p[4], 1'b1);
    endtask

    task automatic test_play_stop();
        run_song("playstop_song1", 1, 1'b0, 6);
        play = 1'b1; song_sel = 2'd2; stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        play = 1'b0; stop = 1'b0;
        check_idle("playstop_busy", 3);
        play = 1'b1; song_sel = 2'd0; stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        play = 1'b0; stop = 1'b0;
        check_idle("playstop_idle", 2);
    endtask

    task automatic test_bad_song();
        play = 1'b1; song_sel = 2'd3;
        @(posedge clk);
        @(negedge clk);
        play = 1'b0;
        check_idle("bad_song", 4);
    endtask

    task automatic test_empty_loop();
        write_entry(2, 0, 5, 0);
        run_song("empty_loop", 2, 1'b1, 0);
        check_obs("empty_busy_t1", obs_b[0], 1'b1);
        check_obs("empty_done_t2", obs_d[1], 1'b1);
    endtask

    task automatic test_collision();
        int cnt;
        build_trace(0, 1'b0, 400);
        cnt = tr.size();
        play = 1'b1; song_sel = 2'd0; loop = 1'b0;
        wr_en = 1'b1; wr_addr = '0; wr_data = {DIV_W'(1), DUR_W'(2)};
        @(posedge clk);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            if (i == 0) begin play = 1'b0; wr_data = {DIV_W'(2), DUR_W'(5)}; end
            if (i == 1) wr_en = 1'b0;
            compare_cycle("collision_old_data", i);
        end
        tbl_div[0][0] = 2;
        tbl_dur[0][0] = 5;
        run_song("collision_new_data", 0, 1'b0, 0);
    endtask

    task automatic test_async_reset();
        run_song("areset_pre", 0, 1'b0, 6);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (piezo_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: piezo/busy/done got %b%b%b, expected 000",
                     piezo_out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_song("areset_replay", 0, 1'b0, 0);
    endtask

    task automatic test_random();
        int song;
        bit lp;
        for (int it = 0; it < 5; it++) begin
            for (int s = 0; s < int'(NS); s++)
                for (int i = 0; i < int'(MN); i++)
                    write_entry(s, i, int'($urandom_range(0, 5)),
                                ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8)));
            for (int r = 0; r < 4; r++) begin
                song = int'($urandom_range(0, NS - 1));
                lp   = 1'($urandom_range(0, 1));
                if (lp) begin
                    run_song("rand_loop", song, 1'b1, 50);
                    if (busy === 1'b1) do_stop("rand_loop_stop");
                end else begin
                    run_song("rand_once", song, 1'b0, 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        setup_tables();
        test_song0();
        test_loop();
        test_full_song();
        test_preempt();
        test_play_stop();
        test_bad_song();
        test_empty_loop();
        test_collision();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
